// File: rtl/chan_mux_pkg.sv
// Shared definitions for the round-robin channel multiplexer.
package chan_mux_pkg;

    // Select-mode encodings for the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Lowest bit of channel ch inside a packed NUM_CH*data_w data bus.
    function automatic int ch_lo(input int ch, input int data_w);
        return ch * data_w;
    endfunction

endpackage

// File: rtl/chan_mux_rr_if.sv
// Handshake bundle between the producers/consumer and the channel mux.
interface chan_mux_rr_if #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
);
    logic                       mode;
    logic [SEL_W-1:0]           sel;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH-1:0]          in_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic [SEL_W-1:0]           out_ch;
    logic                       out_ready;

    // Environment side: drives the producers and the consumer ready.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    // Mux side.
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/chan_mux_rr_arbiter.sv
// Rotating-priority arbiter: the channel after 'last' has top priority.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    // Scan last+1, last+2, ... (mod NUM_CH) and grant the first requester.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] ix;
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last) + k) % NUM_CH;
            ix  = SEL_W'(idx);
            if (!any && req[ix]) begin
                gnt[ix] = 1'b1;
                gnt_idx = ix;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered mux with fixed-select and round-robin modes.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    chan_mux_rr_if.slave  bus
);

    logic [NUM_CH-1:0] rr_gnt;
    logic [NUM_CH-1:0] fix_gnt;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  rr_last;
    logic              rr_any;
    logic              grant_any;
    logic              load;
    logic              xfer;

    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (bus.in_valid),
        .last    (rr_last),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // Fixed mode: grant only the selected channel, and only if it is valid;
    // a sel beyond the last channel matches nothing.
    always_comb begin
        fix_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == SEL_W'(i)) fix_gnt[i] = bus.in_valid[i];
        end
    end

    // Pick the grant source for the current mode.
    always_comb begin
        if (bus.mode == MODE_RR) begin
            grant     = rr_gnt;
            grant_idx = rr_idx;
            grant_any = rr_any;
        end else begin
            grant     = fix_gnt;
            grant_idx = bus.sel;
            grant_any = |fix_gnt;
        end
    end

    // The register can take a word when empty or when being drained this cycle.
    assign load         = !out_valid_q || bus.out_ready;
    assign xfer         = load && grant_any;
    assign bus.in_ready = (rst_n && load) ? grant : '0;

    // Output stage and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last     <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[ch_lo(int'(grant_idx), DATA_W) +: DATA_W];
            out_ch_q    <= grant_idx;
            if (bus.mode == MODE_RR) rr_last <= grant_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Self-checking bench for chan_mux_rr: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_chan_mux_rr;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam logic [31:0] DATA_K = 32'hD3C2B1A0;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    chan_mux_rr_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();
    chan_mux_rr    #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: which channel the rules grant this cycle, -1 for none.
    function automatic int pick(input logic md, input logic [1:0] s, input logic [3:0] v, input int last);
        if (md == 1'b0) return v[s] ? int'(s) : -1;
        for (int k = 1; k <= NCH; k++) begin
            if (v[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    // Model state: what the output register must hold after the last edge.
    logic       m_known = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_last;

    // Compare on every falling edge, then advance the model using the inputs
    // that the next rising edge will sample.
    initial begin
        forever begin
            int         g;
            logic       ld;
            logic [3:0] exp_rdy;
            @(negedge clk);
            ld = !m_valid || bus.out_ready;
            g  = pick(bus.mode, bus.sel, bus.in_valid, m_last);
            if (m_known) begin
                check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
                check("m_out_data",  32'(bus.out_data),  32'(m_data));
                check("m_out_ch",    32'(bus.out_ch),    32'(m_ch));
                exp_rdy = (rst_n && ld && g >= 0) ? 4'(1 << g) : 4'b0000;
                check("m_in_ready",  32'(bus.in_ready),  32'(exp_rdy));
            end
            if (!rst_n) begin
                m_known = 1'b1;
                m_valid = 1'b0;
                m_data  = 8'h00;
                m_ch    = 0;
                m_last  = NCH - 1;
            end else if (m_known) begin
                if (ld && g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = bus.in_data[g*DW +: DW];
                    m_ch    = g;
                    if (bus.mode) m_last = g;
                end else if (bus.out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_seq[6] = '{0, 1, 3, 0, 1, 3};

        rst_n         = 1'b0;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.in_data   = DATA_K;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset held two cycles with every channel valid.
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h00);
        check("rst_out_ch",    32'(bus.out_ch),    32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'b0000);
        rst_n = 1'b1;
        tick();
        check("rel_out_data", 32'(bus.out_data), 32'hA0);
        check("rel_out_ch",   32'(bus.out_ch),   32'd0);

        // Fixed sweep over every channel.
        bus.mode = 1'b0;
        for (int s = 0; s < NCH; s++) begin
            bus.sel = 2'(s);
            #1;
            check("fix_in_ready", 32'(bus.in_ready), 32'(1 << s));
            tick();
            check("fix_out_data", 32'(bus.out_data), 32'(8'hA0 + 8'(s * 8'h11)));
            check("fix_out_ch",   32'(bus.out_ch),   32'(s));
        end
        bus.sel      = 2'd0;
        bus.in_valid = 4'b1110;
        #1;
        check("fix_noval_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("fix_noval_valid", 32'(bus.out_valid), 32'd0);

        // Round-robin fairness and wrap, then a lone requester.
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1011;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_out_ch", 32'(bus.out_ch), 32'(rr_seq[k]));
        end
        bus.in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rr_single_ch", 32'(bus.out_ch), 32'd2);
        end

        // Backpressure: hold three cycles, then same-cycle reload.
        bus.in_valid = 4'b1111;
        do_reset();
        tick();
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_out_data",  32'(bus.out_data),  32'hA0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_reload_ready", 32'(bus.in_ready), 32'b0010);
        tick();
        check("bp_reload_ch",   32'(bus.out_ch),   32'd1);
        check("bp_reload_data", 32'(bus.out_data), 32'hB1);

        // Mode switch: RR pointer survives a stretch of fixed-mode traffic.
        bus.in_valid = 4'b0010;
        do_reset();
        tick();
        check("ms_rr_ch1", 32'(bus.out_ch), 32'd1);
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b1111;
        tick();
        check("ms_fix_ch_a", 32'(bus.out_ch), 32'd2);
        tick();
        check("ms_fix_ch_b", 32'(bus.out_ch), 32'd2);
        bus.mode = 1'b1;
        tick();
        check("ms_resume_ch",   32'(bus.out_ch),   32'd2);
        check("ms_resume_data", 32'(bus.out_data), 32'hC2);

        // Reset while a word is held under backpressure.
        tick();
        bus.out_ready = 1'b0;
        tick();
        check("mid_held_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("mid_restart_ch", 32'(bus.out_ch), 32'd0);

        // Random traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n         = ($urandom_range(0, 99) != 0);
            bus.mode      = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_data   = $urandom;
            bus.in_valid  = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
